uart_word_tx: RTL and testbench

Transmit-side counterpart of the UART word aggregator. It accepts 32-bit words over a valid/ready handshake and serializes each one as four 8N1 UART bytes on `o_uart_tx`, most significant byte first, which is the byte order the aggregator reassembles. It runs in the 25.125 MHz pixel-clock domain. It drives the top-level `o_uart_tx` pin, for status readback and loopback of render positions.

---
 rtl/uart_word_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_word_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx
//
// Serializes 32-bit words as four 8N1 UART bytes, most significant byte
// first. Each byte is a start bit (0), eight data bits sent LSB first, and a
// stop bit (1). Every bit lasts N clocks. N is captured from i_setup when the
// word is accepted, and values below 2 are raised to 2.
//
// Ports:
//   i_clk      clock for all logic (pixel clock)
//   rst        asynchronous, active-high reset; abandons any frame at once
//   i_setup    clocks per bit in i_setup[SETUP_W-1:0]; upper bits ignored
//   i_valid    i_data holds a word to send
//   i_data     word to transmit
//   o_ready    high while idle; a word is accepted when i_valid is also high
//   o_busy     high while a word is being shifted out
//   o_uart_tx  serial line, idle high, driven straight from a flop
module uart_word_tx #(
  parameter int SETUP_W = 24
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic [31:0] i_setup,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_uart_tx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SETUP_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [SETUP_W-1:0] n_q, n_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        shift_q, shift_d;
  logic               tx_q, tx_d;

  logic [SETUP_W-1:0] setup_n;
  logic [SETUP_W-1:0] n_clamped;
  logic               bit_end;
  logic               last_bit;
  logic               last_byte;
  logic [7:0]         byte_d;

  assign setup_n   = i_setup[SETUP_W-1:0];
  // A bit period of one clock would leave no room for the counter reload.
  assign n_clamped = (setup_n < SETUP_W'(2)) ? SETUP_W'(2) : setup_n;
  assign bit_end   = (baud_cnt_q == '0);
  assign last_bit  = (bit_idx_q == 3'd7);
  assign last_byte = (byte_idx_q == 2'd3);

  // Bits of i_setup above the counter width carry no meaning.
  generate
    if (SETUP_W < 32) begin : g_unused_setup
      logic unused_setup_hi;
      assign unused_setup_hi = ^i_setup[31:SETUP_W];
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      n_q        <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      n_q        <= n_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && last_bit) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = last_byte ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter and shift-register updates. The baud counter is reloaded with
  // N-1 on the cycle a bit ends so the next bit also lasts exactly N clocks.
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    n_d        = n_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          shift_d    = i_data;
          n_d        = n_clamped;
          baud_cnt_d = n_clamped - SETUP_W'(1);
          bit_idx_d  = 3'd0;
          byte_idx_d = 2'd0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_cnt_d = n_q - SETUP_W'(1);
          bit_idx_d  = 3'd0;
        end else begin
          baud_cnt_d = baud_cnt_q - SETUP_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = n_q - SETUP_W'(1);
          bit_idx_d  = last_bit ? 3'd0 : bit_idx_q + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt_q - SETUP_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            baud_cnt_d = '0;
            byte_idx_d = 2'd0;
          end else begin
            baud_cnt_d = n_q - SETUP_W'(1);
            byte_idx_d = byte_idx_q + 2'd1;
            // Next byte moves into the top lane, which is always the one sent.
            shift_d    = {shift_q[23:0], 8'h00};
          end
        end else begin
          baud_cnt_d = baud_cnt_q - SETUP_W'(1);
        end
      end
      default: begin
        baud_cnt_d = '0;
      end
    endcase
  end

  // Line level is decided from the upcoming state so the flop shows each bit
  // on the same edge the state machine enters it.
  assign byte_d = shift_d[31:24];

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = (state_q != S_IDLE);
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a queue-based line model predicts the serial
// waveform of every accepted word; a loopback receiver decodes the line
// into bytes for literal checks on byte order and frame timing.
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_setup = 32'd4;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        o_ready;
  logic        o_busy;
  logic        o_uart_tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_word_tx #(.SETUP_W(24)) dut (
    .i_clk    (clk),
    .rst      (rst),
    .i_setup  (i_setup),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_uart_tx(o_uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endfunction

  // Line model: on accept, the whole word's waveform is laid out as a list
  // of per-cycle line levels; each later clock pops one level.
  logic m_busy = 1'b0;
  logic exp_tx = 1'b1;
  logic q_line[$];

  always @(posedge clk or posedge rst) begin
    int n;
    logic [7:0] by;
    if (rst) begin
      m_busy = 1'b0;
      exp_tx = 1'b1;
      q_line.delete();
    end else if (!m_busy) begin
      if (i_valid) begin
        n = int'(i_setup[23:0]);
        if (n < 2) n = 2;
        for (int b = 0; b < 4; b++) begin
          by = i_data[31-8*b -: 8];
          for (int c = 0; c < n; c++) q_line.push_back(1'b0);
          for (int i = 0; i < 8; i++)
            for (int c = 0; c < n; c++) q_line.push_back(by[i]);
          for (int c = 0; c < n; c++) q_line.push_back(1'b1);
        end
        exp_tx = q_line.pop_front();
        m_busy = 1'b1;
      end
    end else if (q_line.size() > 0) begin
      exp_tx = q_line.pop_front();
    end else begin
      exp_tx = 1'b1;
      m_busy = 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("line", o_uart_tx, exp_tx);
      chk("ready", o_ready, !m_busy);
      chk("busy", o_busy, m_busy);
    end
  end

  // Count of cycles with o_ready low; tests take differences.
  int ready_low = 0;
  always @(negedge clk) if (!rst && o_ready === 1'b0) ready_low++;

  // Loopback receiver: finds the start edge, samples each bit mid-period.
  int rx_n = 4;
  logic [7:0] rx_bytes[$];
  int rx_start[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && o_uart_tx === 1'b0) begin
        rx_start.push_back(cyc);
        repeat (rx_n / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (rx_n) @(negedge clk);
          b[i] = o_uart_tx;
        end
        repeat (rx_n) @(negedge clk);
        chk("rx_stop", o_uart_tx, 1);
        rx_bytes.push_back(b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [31:0] s);
    i_data  = d;
    i_setup = s;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (m_busy && k < budget) begin
      tick();
      k++;
    end
    if (m_busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout cyc=%0d actual=busy required=idle", nm, cyc);
    end
  endtask

  task automatic check_word(input string nm, input int base, input logic [31:0] w);
    logic [7:0] e;
    logic [7:0] a;
    for (int b = 0; b < 4; b++) begin
      e = w[31-8*b -: 8];
      a = (rx_bytes.size() > base + b) ? rx_bytes[base+b] : 8'hxx;
      chk($sformatf("%s_byte%0d", nm, b), a, e);
    end
  endtask

  initial begin
    int base, sbase, rl, cnt, k;
    logic [31:0] d, s;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    #3;
    chk("rst_tx", o_uart_tx, 1);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Idle for 1000 cycles.
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (o_uart_tx === 1'b1 && o_ready === 1'b1) cnt++;
    end
    chk("idle_high", cnt, 1000);

    // Single word, N=4.
    rx_n = 4;
    base = rx_bytes.size();
    rl = ready_low;
    send_word(32'hA1B2C3D4, 32'd4);
    wait_done("single", 400);
    tick();
    chk("single_ready_low", ready_low - rl, 160);
    check_word("single", base, 32'hA1B2C3D4);

    // Clamp: setup 0 and 1 both behave as N=2.
    rx_n = 2;
    for (int c = 0; c < 2; c++) begin
      base = rx_bytes.size();
      rl = ready_low;
      send_word(32'h55AA55AA, 32'(c));
      wait_done("clamp", 200);
      tick();
      chk($sformatf("clamp%0d_ready_low", c), ready_low - rl, 80);
      check_word($sformatf("clamp%0d", c), base, 32'h55AA55AA);
    end

    // Back-to-back with i_valid held, N=60.
    rx_n = 60;
    base = rx_bytes.size();
    sbase = rx_start.size();
    i_data = 32'h00000001;
    i_setup = 32'd60;
    i_valid = 1'b1;
    tick();
    i_data = 32'hFFFFFFFF;
    k = 0;
    while (m_busy && k < 3000) begin
      tick();
      k++;
    end
    tick();
    chk("b2b_second_accept", o_busy, 1);
    i_valid = 1'b0;
    wait_done("b2b", 3000);
    tick();
    check_word("b2b_w0", base, 32'h00000001);
    check_word("b2b_w1", base + 4, 32'hFFFFFFFF);
    chk("b2b_gap", (rx_start.size() > sbase + 4) ? rx_start[sbase+4] - rx_start[sbase+3] : -1, 601);

    // Inputs change mid-frame; the frame keeps its latched word and N.
    rx_n = 6;
    base = rx_bytes.size();
    rl = ready_low;
    send_word(32'h12345678, 32'd6);
    repeat (65) tick();
    i_setup = 32'd8;
    i_data = 32'h0;
    i_valid = 1'b1;
    k = 0;
    while (m_busy && k < 400) begin
      tick();
      k++;
    end
    i_valid = 1'b0;
    repeat (3) tick();
    chk("mid_ready_low", ready_low - rl, 240);
    chk("mid_no_second", o_busy, 0);
    check_word("mid", base, 32'h12345678);

    // Reset during bit 3 of byte 2 (that byte is 0x00, so the line is low).
    rx_n = 4;
    send_word(32'h0F1E003C, 32'd4);
    repeat (97) tick();
    chk("pre_rst_tx", o_uart_tx, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", o_uart_tx, 1);
    chk("async_rst_ready", o_ready, 1);
    chk("async_rst_busy", o_busy, 0);
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_busy", o_busy, 0);
    base = rx_bytes.size();
    send_word(32'hCAFEF00D, 32'd4);
    wait_done("post_rst", 400);
    tick();
    check_word("post_rst", base, 32'hCAFEF00D);

    // Random words with input noise while busy.
    for (int w = 0; w < 12; w++) begin
      n = $urandom_range(0, 7);
      d = $urandom();
      s = {8'($urandom_range(0, 255)), 24'(n)};
      rx_n = (n < 2) ? 2 : n;
      base = rx_bytes.size();
      repeat ($urandom_range(0, 3)) tick();
      send_word(d, s);
      k = 0;
      while (m_busy && k < 2000) begin
        if (q_line.size() > 3) begin
          i_valid = 1'($urandom_range(0, 1));
          i_data = $urandom();
          i_setup = $urandom();
        end else begin
          i_valid = 1'b0;
        end
        tick();
        k++;
      end
      i_valid = 1'b0;
      tick();
      chk("rnd_idle", o_ready, 1);
      check_word($sformatf("rnd%0d", w), base, d);
    end

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
